fetch_mt: RTL and testbench

Multi-thread instruction fetch unit; parametrised successor of the single-context fetch stage.
Holds NTHREADS program counters and issues one fetch per cycle, selecting round-robin among active threads.
Tags each returned instruction with its thread id and sends noops (zero) downstream when nothing valid returns.
Supports per-thread branch, fork into a free context, per-thread kill, global stall and core enable; sits between instruction memory and decode.

---
 rtl/fetch_mt_pkg.sv | 16 +
 rtl/fetch_mt_if.sv | 40 ++++
 rtl/fetch_mt_rr_arbiter.sv | 34 +++
 rtl/fetch_mt.sv | 111 +++++++++++
 tb/tb_fetch_mt.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/fetch_mt_pkg.sv
// Shared types and helpers for the multi-thread fetch unit.
package fetch_mt_pkg;

    localparam int TID_MAX_W = 4;
    localparam int unsigned RESET_PC_DEF = 0;

    typedef struct packed {
        logic                 valid;
        logic [TID_MAX_W-1:0] tid;
    } tag_t;

    function automatic int tid_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fetch_mt_if.sv
// Signal bundle of the fetch unit: thread control requests, memory port and decode port.
interface fetch_mt_if #(
    parameter int AW       = 16,
    parameter int IW       = 16,
    parameter int NTHREADS = 4,
    parameter int TIDW     = fetch_mt_pkg::tid_width(NTHREADS)
);
    logic                core_en;
    logic                stall;
    logic                branch_en;
    logic [TIDW-1:0]     branch_tid;
    logic [AW-1:0]       branch_val;
    logic                fork_en;
    logic [AW-1:0]       fork_pc;
    logic                fork_ack;
    logic [TIDW-1:0]     fork_tid;
    logic                fork_full;
    logic                kill_en;
    logic [TIDW-1:0]     kill_tid;
    logic [AW-1:0]       fetch_addr;
    logic [IW-1:0]       fetch_data;
    logic [IW-1:0]       ins;
    logic                ins_valid;
    logic [TIDW-1:0]     ins_tid;
    logic [NTHREADS-1:0] active;

    modport master (
        input  core_en, stall, branch_en, branch_tid, branch_val,
               fork_en, fork_pc, kill_en, kill_tid, fetch_data,
        output fork_ack, fork_tid, fork_full, fetch_addr,
               ins, ins_valid, ins_tid, active
    );

    modport slave (
        output core_en, stall, branch_en, branch_tid, branch_val,
               fork_en, fork_pc, kill_en, kill_tid, fetch_data,
        input  fork_ack, fork_tid, fork_full, fetch_addr,
               ins, ins_valid, ins_tid, active
    );
endinterface

// File: rtl/fetch_mt_rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after ptr, wrapping around.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] idx,
    output logic            any
);
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Wrapped candidates first; a candidate above ptr, if any, overrides them.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && i <= int'(ptr)) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDXW'(i);
                any      = 1'b1;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && i > int'(ptr)) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDXW'(i);
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fetch_mt.sv
// Multi-thread instruction fetch: round-robin issue over NTHREADS PCs with
// thread-tagged return path, branch/kill squash, fork allocation and stall.
module fetch_mt
    import fetch_mt_pkg::*;
#(
    parameter int          AW       = 16,
    parameter int          IW       = 16,
    parameter int          NTHREADS = 4,
    parameter int          TIDW     = tid_width(NTHREADS),
    parameter int unsigned RESET_PC = RESET_PC_DEF,
    parameter int          MEM_LAT  = 1
) (
    input logic        clk,
    input logic        rst,
    fetch_mt_if.master bus
);
    logic [AW-1:0]        pc [NTHREADS];
    logic [NTHREADS-1:0]  active;
    logic [TIDW-1:0]      rr;
    tag_t                 tag_pipe [MEM_LAT];
    logic [AW-1:0]        last_addr;

    logic [NTHREADS-1:0]  sel_oh;
    logic [TIDW-1:0]      sel;
    logic                 any_act;
    logic                 issue;
    logic                 free_any;
    logic [TIDW-1:0]      free_tid;
    logic                 fork_ok;
    logic                 br_take;
    logic [AW-1:0]        addr;
    logic [TID_MAX_W-1:0] sel_x, br_tid_x, kill_tid_x;
    tag_t                 tail;

    function automatic logic squash(input logic [TID_MAX_W-1:0] t,
                                    input logic b_en, input logic [TID_MAX_W-1:0] b_tid,
                                    input logic k_en, input logic [TID_MAX_W-1:0] k_tid);
        return (b_en && t == b_tid) || (k_en && t == k_tid);
    endfunction

    rr_arbiter #(.N(NTHREADS), .IDXW(TIDW)) u_arb (
        .req   (active),
        .ptr   (rr),
        .grant (sel_oh),
        .idx   (sel),
        .any   (any_act)
    );

    always_comb begin
        free_any = 1'b0;
        free_tid = '0;
        for (int i = NTHREADS - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_any = 1'b1;
                free_tid = TIDW'(i);
            end
        end
    end

    assign issue      = !bus.stall && bus.core_en && any_act;
    assign fork_ok    = !rst && !bus.stall && bus.fork_en && free_any;
    assign br_take    = bus.branch_en && !(bus.kill_en && bus.kill_tid == bus.branch_tid);
    assign sel_x      = TID_MAX_W'(sel);
    assign br_tid_x   = TID_MAX_W'(bus.branch_tid);
    assign kill_tid_x = TID_MAX_W'(bus.kill_tid);
    // Holding the address through a stall keeps the memory pipe returning the same data.
    assign addr       = bus.stall ? last_addr : (issue ? pc[sel] : pc[rr]);
    assign tail       = tag_pipe[MEM_LAT-1];

    assign bus.fetch_addr = addr;
    assign bus.fork_ack   = fork_ok;
    assign bus.fork_tid   = free_tid;
    assign bus.fork_full  = !free_any;
    assign bus.ins_valid  = tail.valid;
    assign bus.ins_tid    = TIDW'(tail.tid);
    assign bus.ins        = tail.valid ? bus.fetch_data : '0;
    assign bus.active     = active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTHREADS; i++) pc[i] <= (i == 0) ? AW'(RESET_PC) : '0;
            for (int i = 0; i < MEM_LAT; i++) tag_pipe[i] <= '0;
            active    <= NTHREADS'(1);
            rr        <= TIDW'(NTHREADS - 1);
            last_addr <= AW'(RESET_PC);
        end else if (!bus.stall) begin
            last_addr <= addr;
            if (issue) rr <= sel;
            // Later writes win: branch overrides increment, fork owns a free context.
            for (int i = 0; i < NTHREADS; i++) begin
                if (issue && sel_oh[i]) pc[i] <= pc[i] + AW'(1);
                if (br_take && bus.branch_tid == TIDW'(i)) pc[i] <= bus.branch_val;
                if (bus.kill_en && active[i] && bus.kill_tid == TIDW'(i)) active[i] <= 1'b0;
                if (fork_ok && free_tid == TIDW'(i)) begin
                    pc[i]     <= bus.fork_pc;
                    active[i] <= 1'b1;
                end
            end
            // Tag pipe stage boundary: head takes this cycle's issue, others shift toward tail.
            tag_pipe[0] <= '{valid: issue && !squash(sel_x, bus.branch_en, br_tid_x,
                                                     bus.kill_en, kill_tid_x),
                             tid: sel_x};
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_pipe[i] <= '{valid: tag_pipe[i-1].valid && bus.core_en &&
                                        !squash(tag_pipe[i-1].tid, bus.branch_en, br_tid_x,
                                                bus.kill_en, kill_tid_x),
                                 tid: tag_pipe[i-1].tid};
            end
        end
    end
endmodule

// File: tb/tb_fetch_mt.sv
// Directed table-driven bench for fetch_mt (4 threads, 2-cycle memory).
module tb_fetch_mt;
    import fetch_mt_pkg::*;

    localparam int AW = 16;
    localparam int IW = 16;
    localparam int NT = 4;
    localparam int TW = 2;
    localparam int ML = 2;
    localparam int NV = 27;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fetch_mt_if #(.AW(AW), .IW(IW), .NTHREADS(NT), .TIDW(TW)) bus ();

    fetch_mt #(.AW(AW), .IW(IW), .NTHREADS(NT), .TIDW(TW), .RESET_PC(0), .MEM_LAT(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory: data is a fixed scramble of the address, delivered ML unstalled cycles later.
    function automatic logic [IW-1:0] mdata(input logic [AW-1:0] a);
        return a ^ 16'hC3C3;
    endfunction

    logic [AW-1:0] mem_q [ML];
    always @(posedge clk) begin
        if (!bus.stall) begin
            mem_q[0] <= bus.fetch_addr;
            for (int k = 1; k < ML; k++) mem_q[k] <= mem_q[k-1];
        end
    end
    assign bus.fetch_data = mdata(mem_q[ML-1]);

    typedef struct {
        logic        ce, st, be, fe, ke;
        logic [1:0]  bt, kt;
        logic [15:0] bv, fp;
        logic [15:0] e_addr, e_iaddr;
        logic        e_vld, e_ack, e_full;
        logic [1:0]  e_tid, e_ftid;
        logic [3:0]  e_act;
    } vec_t;

    vec_t vt [NV];

    function automatic vec_t V(input int ce, st, be, bt, bv, fe, fp, ke, kt,
                               input int ea, ev, et, eia, eack, eft, efull, eact);
        vec_t v;
        v.ce = 1'(ce);  v.st = 1'(st);  v.be = 1'(be);  v.bt = 2'(bt);  v.bv = 16'(bv);
        v.fe = 1'(fe);  v.fp = 16'(fp); v.ke = 1'(ke);  v.kt = 2'(kt);
        v.e_addr = 16'(ea); v.e_vld = 1'(ev); v.e_tid = 2'(et); v.e_iaddr = 16'(eia);
        v.e_ack = 1'(eack); v.e_ftid = 2'(eft); v.e_full = 1'(efull); v.e_act = 4'(eact);
        return v;
    endfunction

    task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.core_en = v.ce; bus.stall = v.st;
        bus.branch_en = v.be; bus.branch_tid = v.bt; bus.branch_val = v.bv;
        bus.fork_en = v.fe; bus.fork_pc = v.fp;
        bus.kill_en = v.ke; bus.kill_tid = v.kt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          ce st be bt bv     fe fp     ke kt  addr   v tid iaddr  ack ft full act
        vt[0]  = V(1, 0, 0, 0, 0,     0, 0,     0, 0,  'h000, 0, 0, 0,     0, 0, 0, 'b0001);
        vt[1]  = V(1, 0, 0, 0, 0,     0, 0,     0, 0,  'h001, 0, 0, 0,     0, 0, 0, 'b0001);
        vt[2]  = V(1, 0, 0, 0, 0,     0, 0,     0, 0,  'h002, 1, 0, 'h000, 0, 0, 0, 'b0001);
        vt[3]  = V(1, 0, 0, 0, 0,     1, 'h100, 0, 0,  'h003, 1, 0, 'h001, 1, 1, 0, 'b0001);
        vt[4]  = V(1, 0, 0, 0, 0,     0, 0,     0, 0,  'h100, 1, 0, 'h002, 0, 0, 0, 'b0011);
        vt[5]  = V(1, 0, 0, 0, 0,     0, 0,     0, 0,  'h004, 1, 0, 'h003, 0, 0, 0, 'b0011);
        vt[6]  = V(1, 0, 0, 0, 0,     0, 0,     0, 0,  'h101, 1, 1, 'h100, 0, 0, 0, 'b0011);
        vt[7]  = V(1, 0, 1, 1, 'h200, 0, 0,     0, 0,  'h005, 1, 0, 'h004, 0, 0, 0, 'b0011);
        vt[8]  = V(1, 0, 1, 1, 'h300, 0, 0,     0, 0,  'h200, 0, 0, 0,     0, 0, 0, 'b0011);
        vt[9]  = V(1, 0, 0, 0, 0,     0, 0,     0, 0,  'h006, 1, 0, 'h005, 0, 0, 0, 'b0011);
        vt[10] = V(1, 0, 0, 0, 0,     0, 0,     0, 0,  'h300, 0, 0, 0,     0, 0, 0, 'b0011);
        vt[11] = V(1, 0, 0, 0, 0,     1, 'h400, 0, 0,  'h007, 1, 0, 'h006, 1, 2, 0, 'b0011);
        vt[12] = V(1, 0, 0, 0, 0,     1, 'h500, 0, 0,  'h301, 1, 1, 'h300, 1, 3, 0, 'b0111);
        vt[13] = V(1, 0, 0, 0, 0,     1, 'h600, 0, 0,  'h400, 1, 0, 'h007, 0, 0, 1, 'b1111);
        vt[14] = V(1, 0, 0, 0, 0,     1, 'h700, 1, 2,  'h500, 1, 1, 'h301, 0, 0, 1, 'b1111);
        vt[15] = V(1, 0, 0, 0, 0,     1, 'h700, 0, 0,  'h008, 0, 0, 0,     1, 2, 0, 'b1011);
        vt[16] = V(1, 0, 0, 0, 0,     0, 0,     0, 0,  'h302, 1, 3, 'h500, 0, 0, 1, 'b1111);
        vt[17] = V(1, 1, 1, 0, 'hAAA, 0, 0,     0, 0,  'h302, 1, 0, 'h008, 0, 0, 1, 'b1111);
        vt[18] = V(1, 1, 0, 0, 0,     1, 'h800, 0, 0,  'h302, 1, 0, 'h008, 0, 0, 1, 'b1111);
        vt[19] = V(1, 1, 0, 0, 0,     0, 0,     1, 1,  'h302, 1, 0, 'h008, 0, 0, 1, 'b1111);
        vt[20] = V(1, 0, 0, 0, 0,     0, 0,     0, 0,  'h700, 1, 0, 'h008, 0, 0, 1, 'b1111);
        vt[21] = V(1, 0, 0, 0, 0,     0, 0,     0, 0,  'h501, 1, 1, 'h302, 0, 0, 1, 'b1111);
        vt[22] = V(1, 0, 0, 0, 0,     0, 0,     0, 0,  'h009, 1, 2, 'h700, 0, 0, 1, 'b1111);
        vt[23] = V(0, 0, 0, 0, 0,     0, 0,     0, 0,  'h00A, 1, 3, 'h501, 0, 0, 1, 'b1111);
        vt[24] = V(1, 0, 0, 0, 0,     0, 0,     0, 0,  'h303, 0, 0, 0,     0, 0, 1, 'b1111);
        vt[25] = V(1, 0, 0, 0, 0,     0, 0,     0, 0,  'h701, 0, 0, 0,     0, 0, 1, 'b1111);
        vt[26] = V(1, 0, 0, 0, 0,     0, 0,     0, 0,  'h502, 1, 1, 'h303, 0, 0, 1, 'b1111);

        // Reset, with a fork request pending that must not be acknowledged.
        rst = 1'b1;
        apply(V(0, 0, 0, 0, 0, 1, 'h900, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ins_valid", -1, 32'(bus.ins_valid), 32'd0);
        chk("rst_ins",       -1, 32'(bus.ins),       32'd0);
        chk("rst_ins_tid",   -1, 32'(bus.ins_tid),   32'd0);
        chk("rst_fork_ack",  -1, 32'(bus.fork_ack),  32'd0);
        chk("rst_active",    -1, 32'(bus.active),    32'd1);
        chk("rst_addr",      -1, 32'(bus.fetch_addr), 32'd0);
        rst = 1'b0;
        bus.fork_en = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < NV; n++) begin
            apply(vt[n]);
            @(negedge clk);
            chk("fetch_addr", n, 32'(bus.fetch_addr), 32'(vt[n].e_addr));
            chk("ins_valid",  n, 32'(bus.ins_valid),  32'(vt[n].e_vld));
            if (vt[n].e_vld) begin
                chk("ins_tid", n, 32'(bus.ins_tid), 32'(vt[n].e_tid));
                chk("ins",     n, 32'(bus.ins),     32'(mdata(vt[n].e_iaddr)));
            end else begin
                chk("ins_zero", n, 32'(bus.ins), 32'd0);
            end
            chk("fork_ack",  n, 32'(bus.fork_ack),  32'(vt[n].e_ack));
            if (vt[n].e_ack) chk("fork_tid", n, 32'(bus.fork_tid), 32'(vt[n].e_ftid));
            chk("fork_full", n, 32'(bus.fork_full), 32'(vt[n].e_full));
            chk("active",    n, 32'(bus.active),    32'(vt[n].e_act));
            @(posedge clk); #1;
        end

        // Asynchronous reset between edges while a valid instruction is on the output.
        #2;
        chk("pre_rst_valid", 100, 32'(bus.ins_valid), 32'd1);
        chk("pre_rst_tid",   100, 32'(bus.ins_tid),   32'd2);
        chk("pre_rst_ins",   100, 32'(bus.ins),       32'(mdata(16'h0701)));
        rst = 1'b1;
        #1;
        chk("async_ins_valid", 101, 32'(bus.ins_valid), 32'd0);
        chk("async_ins",       101, 32'(bus.ins),       32'd0);
        chk("async_ins_tid",   101, 32'(bus.ins_tid),   32'd0);
        chk("async_active",    101, 32'(bus.active),    32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_addr",   102, 32'(bus.fetch_addr), 32'd0);
        chk("post_rst_active", 102, 32'(bus.active),     32'd1);
        @(posedge clk); #1;
        chk("post_rst_addr1",  103, 32'(bus.fetch_addr), 32'd1);
        chk("post_rst_valid1", 103, 32'(bus.ins_valid),  32'd0);
        @(posedge clk); #1;
        chk("post_rst_addr2",  104, 32'(bus.fetch_addr), 32'd2);
        chk("post_rst_valid2", 104, 32'(bus.ins_valid),  32'd1);
        chk("post_rst_tid2",   104, 32'(bus.ins_tid),    32'd0);
        chk("post_rst_ins2",   104, 32'(bus.ins),        32'(mdata(16'h0000)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
